// File: rtl/hr_bridge_fifo.sv
// Transfer buffer behind one hierarchical-ring bridge FIFO port: stores pushed flits,
// presents the head flit, drives a registered bfull with skid slack and sticky error flags.
module hr_bridge_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enQ_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             deQ_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bfull_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SKID_L    = (AW+1)'(SKID);
  localparam logic [AW:0]   CNT_ONE_L = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_L = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wp_r;
  logic [AW-1:0]    rp_r;
  logic [AW:0]      cnt_r;
  logic             bfull_r;
  logic             ovf_r;
  logic             udf_r;

  logic             pop_s;
  logic             psh_s;
  logic [AW:0]      cnt_nxt_s;

  // Accept/reject decisions and next occupancy; a pop on an empty queue never
  // falls through to a same-cycle push.
  always_comb begin
    pop_s = deQ_i & (cnt_r != {(AW+1){1'b0}});
    psh_s = enQ_i & ((cnt_r < DEPTH_L) | pop_s);
    case ({psh_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE_L;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE_L;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Flit storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (psh_s) begin
      mem_r[wp_r] <= data_i;
    end
  end

  // Pointers, occupancy, registered bfull and sticky protocol-error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r    <= {AW{1'b0}};
      rp_r    <= {AW{1'b0}};
      cnt_r   <= {(AW+1){1'b0}};
      bfull_r <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (psh_s) begin
        wp_r <= wp_r + PTR_ONE_L;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE_L;
      end
      cnt_r   <= cnt_nxt_s;
      // cnt_nxt_s never exceeds DEPTH, so the subtraction cannot wrap.
      bfull_r <= ((DEPTH_L - cnt_nxt_s) <= SKID_L);
      if (enQ_i && !psh_s) begin
        ovf_r <= 1'b1;
      end
      if (deQ_i && !pop_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  // Head flit from registered state only; an all-zero flit marks "nothing valid".
  always_comb begin
    if (cnt_r != {(AW+1){1'b0}}) begin
      data_o = mem_r[rp_r];
    end else begin
      data_o = {WIDTH{1'b0}};
    end
  end

  assign bfull_o = bfull_r;
  assign empty_o = (cnt_r == {(AW+1){1'b0}});
  assign count_o = cnt_r;
  assign ovf_o   = ovf_r;
  assign udf_o   = udf_r;

endmodule

// File: tb/tb_hr_bridge_fifo.sv
// Self-checking bench for hr_bridge_fifo (WIDTH=144, DEPTH=4, SKID=1): directed test-plan
// scenarios plus random traffic, checked against a queue-based reference model.
module tb_hr_bridge_fifo;

  localparam int W = 144;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         enq;
  logic         deq;
  logic [W-1:0] din;
  logic [W-1:0] data_o;
  logic         bfull_o;
  logic         empty_o;
  logic [2:0]   count_o;
  logic         ovf_o;
  logic         udf_o;

  int nchk;
  int nfail;

  logic [W-1:0] q[$];
  logic         m_ovf;
  logic         m_udf;
  logic         m_bfull;

  hr_bridge_fifo #(.WIDTH(W), .DEPTH(D), .AW(2), .SKID(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .enQ_i   (enq),
    .data_i  (din),
    .deQ_i   (deq),
    .data_o  (data_o),
    .bfull_o (bfull_o),
    .empty_o (empty_o),
    .count_o (count_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] flit(input logic [15:0] k);
    return {128'h0123456789abcdef0123456789abcdef, k};
  endfunction

  function automatic logic [W-1:0] head();
    if (q.size() != 0) return q[0];
    return {W{1'b0}};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"},  data_o,           head());
    chk({tag, ".count"}, W'(count_o),      W'(q.size()));
    chk({tag, ".empty"}, W'(empty_o),      W'(q.size() == 0));
    chk({tag, ".bfull"}, W'(bfull_o),      W'(m_bfull));
    chk({tag, ".ovf"},   W'(ovf_o),        W'(m_ovf));
    chk({tag, ".udf"},   W'(udf_o),        W'(m_udf));
  endtask

  // One clock cycle: drive inputs, confirm data_o ignores them, apply the edge, compare.
  task automatic step(input logic e, input logic d, input logic [W-1:0] x, input string tag);
    logic do_pop;
    logic do_psh;
    @(negedge clk);
    enq = e;
    deq = d;
    din = x;
    #1;
    chk({tag, ".comb"}, data_o, head());
    @(posedge clk);
    do_pop = d && (q.size() != 0);
    do_psh = e && ((q.size() < D) || do_pop);
    if (e && !do_psh) m_ovf = 1'b1;
    if (d && !do_pop) m_udf = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (do_psh) q.push_back(x);
    m_bfull = ((D - q.size()) <= 1);
    #1;
    chk_all(tag);
    enq = 1'b0;
    deq = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_bfull = 1'b0;
    #1;
    chk_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    rst   = 1'b1;
    enq   = 1'b0;
    deq   = 1'b0;
    din   = {W{1'b0}};
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_bfull = 1'b0;
    @(negedge clk);

    // Reset then single push
    do_reset("rst0");
    step(1'b1, 1'b0, flit(16'h1851), "push1");
    chk("push1.head_const", data_o, flit(16'h1851));

    // Fill to full, overflow, drain
    do_reset("rst1");
    step(1'b1, 1'b0, flit(16'h1850), "fill1");
    step(1'b1, 1'b0, flit(16'h1854), "fill2");
    chk("fill2.bfull_low", W'(bfull_o), W'(1'b0));
    step(1'b1, 1'b0, flit(16'h1857), "fill3");
    chk("fill3.bfull_high", W'(bfull_o), W'(1'b1));
    step(1'b1, 1'b0, flit(16'h185a), "fill4");
    step(1'b1, 1'b0, flit(16'h185f), "ovf");
    chk("ovf.flag_const", W'(ovf_o), W'(1'b1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, {W{1'b0}}, "drain");
    chk("drain.zero", data_o, {W{1'b0}});

    // Full with simultaneous push and pop
    do_reset("rst2");
    step(1'b1, 1'b0, flit(16'h1850), "f2a");
    step(1'b1, 1'b0, flit(16'h1854), "f2b");
    step(1'b1, 1'b0, flit(16'h1857), "f2c");
    step(1'b1, 1'b0, flit(16'h185a), "f2d");
    step(1'b1, 1'b1, flit(16'h185f), "fullpp");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, {W{1'b0}}, "drain2");

    // Empty: pop only, then push+pop
    do_reset("rst3");
    step(1'b0, 1'b1, {W{1'b0}}, "udf");
    step(1'b1, 1'b1, flit(16'h1860), "emptypp");
    chk("emptypp.head_const", data_o, flit(16'h1860));

    // Streaming across pointer wrap at count 2
    do_reset("rst4");
    step(1'b1, 1'b0, flit(16'h2000), "pre0");
    step(1'b1, 1'b0, flit(16'h2001), "pre1");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, flit(16'(16'h2002 + i)), "stream");
    chk("stream.count_const", W'(count_o), W'(3'd2));
    step(1'b0, 1'b1, {W{1'b0}}, "post0");
    step(1'b0, 1'b1, {W{1'b0}}, "post1");

    // Random traffic
    do_reset("rst5");
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())}, "rand");
    end

    // Asynchronous reset mid-stream with three entries
    do_reset("rst6");
    step(1'b1, 1'b0, flit(16'h3000), "m0");
    step(1'b1, 1'b0, flit(16'h3001), "m1");
    step(1'b1, 1'b0, flit(16'h3002), "m2");
    chk("m2.count_const", W'(count_o), W'(3'd3));
    @(negedge clk);
    do_reset("async");
    chk("async.data_zero", data_o, {W{1'b0}});
    step(1'b1, 1'b0, flit(16'h3100), "postrst");
    chk("postrst.head_const", data_o, flit(16'h3100));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/hr_bridge_fifo.md
# hr_bridge_fifo

Transfer buffer on the far side of the hierarchical-ring bridge's FIFO interface: it receives flits pushed by the bridge (enQ + FIFO data out) and presents a head flit for the bridge to pop (deQ). One instance sits on each of the six bridge FIFO ports (l0, l1, g0–g3). It produces the bridge's bfull input with enough slack for one in-flight flit, and flags overflow/underflow protocol errors.

## Interface
- WIDTH, 144, flit width; equals `control_w
- DEPTH, 4, entries; power of two, ≥2
- AW, 2, log2(DEPTH)
- SKID, 1, free-slot threshold at or below which bfull_o asserts; 1 ≤ SKID < DEPTH
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- enQ_i  input  1  push strobe from bridge enQ_*_o
- data_i  input  WIDTH  flit from bridge FIFO_*_o; sampled when enQ_i=1
- deQ_i  input  1  pop strobe from bridge deQ_*_o
- data_o  output  WIDTH  head flit to bridge FIFO_*_i; all zeros when empty
- bfull_o  output  1  to bridge bfull_*_i; registered
- empty_o  output  1  no entries stored
- count_o  output  AW+1  occupancy, 0..DEPTH
- ovf_o  output  1  sticky: push dropped while full
- udf_o  output  1  sticky: pop while empty

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp and read pointer rp (AW bits, wrap DEPTH-1→0), occupancy counter cnt (AW+1 bits).
- Push accepted (psh) = enQ_i & (cnt<DEPTH | pop accepted same cycle). Accepted push writes data_i at mem[wp], wp+1.
- Pop accepted (pop) = deQ_i & cnt≠0. Accepted pop advances rp+1; popped flit is the one on data_o in that cycle.
- cnt next = cnt + psh − pop; never exceeds DEPTH, never below 0.
- Full with simultaneous enQ_i and deQ_i: both accepted, cnt stays DEPTH.
- Empty with simultaneous enQ_i and deQ_i: push accepted, pop ignored (no fall-through), udf_o sets, cnt→1.
- enQ_i while full without deQ_i: flit dropped, state unchanged, ovf_o sets.
- deQ_i while empty: ignored, udf_o sets.
- ovf_o/udf_o cleared only by reset.
- data_o = mem[rp] when cnt≠0, else WIDTH'h0 (zero flit = invalid to bridge). Combinational from registered state only; no path from any input.
- bfull_o register next value = (DEPTH − cnt_next) ≤ SKID.
- empty_o = (cnt==0); count_o = cnt.
- Storage contents not reset; only pointers, count and flags.

## Timing
- Reset (rst=0, asynchronous, immediate): wp=rp=0, cnt=0, data_o=0, empty_o=1, count_o=0, bfull_o=0, ovf_o=0, udf_o=0. Reset mid-operation discards all stored flits.
- Push latency: flit pushed at edge N is visible on data_o after edge N (cycle N+1) if queue was empty.
- Pop: data_o changes to next entry (or zero) after the pop edge.
- bfull_o valid the cycle after the edge that changed occupancy; with SKID=1 the bridge may issue one further enQ after bfull_o rises without loss.
- Pointer wrap-around: continuous push/pop across ≥2·DEPTH flits returns data in order with no gaps.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then push 144'h0123456789abcdef0123456789abcdef1851 -> next cycle data_o equals it, count_o=1, empty_o=0, bfull_o=0.
- Push 4 distinct flits (…1850, …1854, …1857, …185a) back-to-back, DEPTH=4, SKID=1 -> bfull_o=1 after 3rd push edge, count_o=4 after 4th; 5th push …185f dropped, ovf_o=1, pops return 1850,1854,1857,185a then data_o=0.
- Full queue, enQ_i and deQ_i together with …185f -> count_o stays 4, order preserved, …185f emerges last, ovf_o=0.
- Empty queue, deQ_i only -> udf_o=1, count_o=0, data_o=0; empty with enQ_i+deQ_i -> count_o=1, flit held.
- Stream 10 flits with 1 push + 1 pop per cycle from count 2 -> in-order output across pointer wrap, count_o constant 2.
- Assert rst low asynchronously mid-stream with count_o=3 -> all outputs immediately at reset values; first post-reset push appears on data_o next cycle.
